alu_exec_unit: RTL and testbench

//  EX-stage execute unit consuming the 4-bit ALU control code from the ALU control decoder.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/mul_seq.sv | 66 ++++++
 rtl/alu_exec_unit.sv | 146 ++++++++++++++
 tb/tb_alu_exec_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared op-code constants, issue-FSM state encoding and helpers
// for the EX-stage execute unit (alu_exec_unit) and its multiplier.
package alu_pkg;

    localparam logic [3:0] ALU_MULT = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SLLI = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_BEQ  = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_BGE  = 4'd7;
    localparam logic [3:0] ALU_MATR = 4'd8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    // True for the op codes that run on the iterative multiplier.
    function automatic logic is_multi_cycle(input logic [3:0] code);
        return (code == ALU_MULT) || (code == ALU_MATR);
    endfunction

endpackage

// File: rtl/mul_seq.sv
// mul_seq: iterative shift-add multiplier, one multiplier bit per cycle,
// LSB first. done/product_lo are combinational for the finishing cycle so
// the parent can register the result on that same edge.
// Optional: MUL_EARLY_TERM_EN stops as soon as the remaining multiplier bits are all 0.
module mul_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] product_lo
);

    localparam int CW = $clog2(XLEN);

    logic            busy;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] prod;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] prod_next;
    logic            last;

    // Partial-product accumulation and end-of-operation detection for this cycle.
    always_comb begin
        prod_next = prod + (mplier[0] ? mcand : '0);
`ifdef MUL_EARLY_TERM_EN
        last = (count == CW'(XLEN - 1)) || ((mplier >> 1) == '0);
`else
        last = (count == CW'(XLEN - 1));
`endif
        done       = busy && last && !flush;
        product_lo = prod_next;
    end

    // Shift registers and iteration counter; flush abandons the operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            count  <= '0;
        end else if (start && !busy) begin
            busy   <= 1'b1;
            mcand  <= a;
            mplier <= b;
            prod   <= '0;
            count  <= '0;
        end else if (busy) begin
            if (flush || last) begin
                busy <= 1'b0;
            end else begin
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                prod   <= prod_next;
                count  <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage execute unit. Single-cycle ops produce a registered
// result one edge after issue; mult/matr run on mul_seq and hold stall high.
// matr accumulates into a private accumulator (acc += a*b).
// Optional: MUL_EARLY_TERM_EN (passed through to mul_seq) shortens multiplies.
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            stall
);
    import alu_pkg::*;

    logic [0:0]      state;
    logic            is_matr_q;
    logic [XLEN-1:0] acc;
    logic            issue;
    logic            issue_mul;
    logic            issue_single;
    logic            mul_done;
    logic [XLEN-1:0] product_lo;
    logic [XLEN-1:0] mul_result;
    logic [XLEN-1:0] diff;
    logic [XLEN-1:0] single_result;
    logic            single_zero;

    assign in_ready = (state == ST_IDLE);
    assign stall    = (state == ST_MUL);

    // Issue qualification: flush kills anything offered in the same cycle.
    always_comb begin
        issue        = in_valid && (state == ST_IDLE) && !flush;
        issue_mul    = issue && is_multi_cycle(alu_ctrl);
        issue_single = issue && !is_multi_cycle(alu_ctrl);
        mul_result   = is_matr_q ? (acc + product_lo) : product_lo;
    end

    // Single-cycle datapath; undefined codes yield result 0 with zero set.
    always_comb begin
        diff          = op_a - op_b;
        single_result = '0;
        single_zero   = 1'b1;
        case (alu_ctrl)
            ALU_ADD: begin
                single_result = op_a + op_b;
                single_zero   = (single_result == '0);
            end
            ALU_SUB: begin
                single_result = diff;
                single_zero   = (diff == '0);
            end
            ALU_XOR: begin
                single_result = op_a ^ op_b;
                single_zero   = (single_result == '0);
            end
            ALU_SLLI: begin
                single_result = op_a << op_b[4:0];
                single_zero   = (single_result == '0);
            end
            ALU_BEQ: begin
                single_result = diff;
                single_zero   = (op_a == op_b);
            end
            ALU_BGE: begin
                single_result = diff;
                single_zero   = ($signed(op_a) >= $signed(op_b));
            end
            default: begin
                single_result = '0;
                single_zero   = 1'b1;
            end
        endcase
    end

    mul_seq #(.XLEN(XLEN)) u_mul_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (issue_mul),
        .flush      (flush),
        .a          (op_a),
        .b          (op_b),
        .done       (mul_done),
        .product_lo (product_lo)
    );

    // Issue FSM: IDLE -> MUL on a multiply issue, back on completion or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            is_matr_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (issue_mul) begin
                        state     <= ST_MUL;
                        is_matr_q <= (alu_ctrl == ALU_MATR);
                    end
                end
                default: begin
                    if (flush || mul_done) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Output registers: result/zero hold between ops, out_valid is a one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (issue_single) begin
                result    <= single_result;
                zero      <= single_zero;
                out_valid <= 1'b1;
            end else if (mul_done) begin
                result    <= mul_result;
                zero      <= (mul_result == '0);
                out_valid <= 1'b1;
            end
        end
    end

    // matr accumulator: updated only when a matr completes without flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (mul_done && is_matr_q) begin
            acc <= mul_result;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: self-checking bench for alu_exec_unit. A behavioural model
// (plain arithmetic plus a latency countdown) predicts every output after every
// edge; directed literal checks pin the model. Honours MUL_EARLY_TERM_EN.
module tb_alu_exec_unit;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            out_valid;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            stall;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic            m_busy;
    int              m_rem;
    logic [XLEN-1:0] m_a, m_b, m_acc, m_result;
    logic            m_matr, m_zero, m_valid;

    alu_exec_unit #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .flush     (flush),
        .out_valid (out_valid),
        .result    (result),
        .zero      (zero),
        .stall     (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [XLEN-1:0] act,
                               input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int mulCycles(input logic [XLEN-1:0] b);
`ifdef MUL_EARLY_TERM_EN
        int hi;
        hi = -1;
        for (int i = 0; i < XLEN; i++) if (b[i]) hi = i;
        return (hi < 0) ? 1 : hi + 1;
`else
        return XLEN;
`endif
    endfunction

    task automatic modelReset();
        m_busy = 0; m_rem = 0; m_a = '0; m_b = '0; m_matr = 0;
        m_acc = '0; m_result = '0; m_zero = 0; m_valid = 0;
    endtask

    // Advance the model by one clock edge using the inputs the DUT just sampled.
    task automatic modelEdge();
        logic [2*XLEN-1:0] full;
        logic [XLEN-1:0]   r;
        m_valid = 0;
        if (m_busy) begin
            if (flush) begin
                m_busy = 0;
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    full = {{XLEN{1'b0}}, m_a} * {{XLEN{1'b0}}, m_b};
                    r = full[XLEN-1:0];
                    if (m_matr) begin
                        r = r + m_acc;
                        m_acc = r;
                    end
                    m_result = r; m_zero = (r == 0); m_valid = 1; m_busy = 0;
                end
            end
        end else if (in_valid && !flush) begin
            case (alu_ctrl)
                4'd1, 4'd8: begin
                    m_busy = 1; m_rem = mulCycles(op_b);
                    m_a = op_a; m_b = op_b; m_matr = (alu_ctrl == 4'd8);
                end
                4'd2: begin m_result = op_a + op_b; m_zero = (m_result == 0); end
                4'd6: begin m_result = op_a - op_b; m_zero = (m_result == 0); end
                4'd4: begin m_result = op_a ^ op_b; m_zero = (m_result == 0); end
                4'd3: begin m_result = op_a << op_b[4:0]; m_zero = (m_result == 0); end
                4'd5: begin m_result = op_a - op_b; m_zero = (op_a == op_b); end
                4'd7: begin m_result = op_a - op_b; m_zero = ($signed(op_a) >= $signed(op_b)); end
                default: begin m_result = 0; m_zero = 1; end
            endcase
            if (!m_busy) m_valid = 1;
        end
    endtask

    task automatic compareModel();
        checkOutput("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        checkOutput("result", result, m_result);
        checkOutput("zero", {31'd0, zero}, {31'd0, m_zero});
        checkOutput("stall", {31'd0, stall}, {31'd0, m_busy});
        checkOutput("in_ready", {31'd0, in_ready}, {31'd0, !m_busy});
    endtask

    // Drive one cycle of inputs, clock it, advance the model and compare.
    task automatic applyStimulus(input logic v, input logic [3:0] c,
                                 input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                 input logic f);
        in_valid = v; alu_ctrl = c; op_a = a; op_b = b; flush = f;
        @(posedge clk);
        modelEdge();
        #1;
        compareModel();
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 4'd0, '0, '0, 1'b0);
    endtask

    // Asynchronous reset pulse issued between edges, checked while asserted.
    task automatic doReset();
        in_valid = 0; flush = 0;
        rst_n = 0;
        #1;
        modelReset();
        compareModel();
        checkOutput("rst_stall", {31'd0, stall}, 32'd0);
        checkOutput("rst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1;
        idleCycle();
    endtask

    // Issue a multiply-class op and wait (bounded) for its out_valid.
    task automatic runMulOp(input logic [3:0] c, input logic [XLEN-1:0] a,
                            input logic [XLEN-1:0] b, output logic [XLEN-1:0] res,
                            output int lat);
        applyStimulus(1'b1, c, a, b, 1'b0);
        lat = 1;
        while (!out_valid && lat < 100) begin
            idleCycle();
            lat++;
        end
        if (!out_valid) checkOutput("mul_timeout", 32'd0, 32'd1);
        res = result;
    endtask

    initial begin
        logic [XLEN-1:0] res;
        int              lat;
        int              code;

        rst_n = 0; in_valid = 0; alu_ctrl = 0; op_a = 0; op_b = 0; flush = 0;
        modelReset();
        #12;
        compareModel();
        checkOutput("reset_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1;
        idleCycle();

        // add wrap: FFFFFFFF + 1
        applyStimulus(1'b1, 4'd2, 32'hFFFF_FFFF, 32'd1, 1'b0);
        checkOutput("add_wrap_res", result, 32'd0);
        checkOutput("add_wrap_zero", {31'd0, zero}, 32'd1);
        checkOutput("add_wrap_vld", {31'd0, out_valid}, 32'd1);

        // bge -2 >= 1 is false, then back-to-back beq 5 == 5
        applyStimulus(1'b1, 4'd7, 32'hFFFF_FFFE, 32'd1, 1'b0);
        checkOutput("bge_res", result, 32'hFFFF_FFFD);
        checkOutput("bge_zero", {31'd0, zero}, 32'd0);
        applyStimulus(1'b1, 4'd5, 32'd5, 32'd5, 1'b0);
        checkOutput("beq_zero", {31'd0, zero}, 32'd1);
        checkOutput("beq_vld", {31'd0, out_valid}, 32'd1);

        // slli to the top bit, undefined code, flush in IDLE
        applyStimulus(1'b1, 4'd3, 32'd1, 32'd31, 1'b0);
        checkOutput("slli_res", result, 32'h8000_0000);
        applyStimulus(1'b1, 4'd12, 32'd9, 32'd3, 1'b0);
        checkOutput("undef_res", result, 32'd0);
        checkOutput("undef_zero", {31'd0, zero}, 32'd1);
        applyStimulus(1'b1, 4'd2, 32'd1, 32'd1, 1'b1);
        checkOutput("flush_idle_vld", {31'd0, out_valid}, 32'd0);

        // mult 7*6
        runMulOp(4'd1, 32'd7, 32'd6, res, lat);
        checkOutput("mult_res", res, 32'd42);
        checkOutput("mult_zero", {31'd0, zero}, 32'd0);
`ifdef MUL_EARLY_TERM_EN
        checkOutput("mult_lat", lat, 32'd4);
        runMulOp(4'd1, 32'd5, 32'd2, res, lat);
        checkOutput("early_res", res, 32'd10);
        checkOutput("early_lat", lat, 32'd3);
`else
        checkOutput("mult_lat", lat, 32'd33);
`endif

        // matr accumulation, reset mid-MUL, accumulator cleared
        doReset();
        runMulOp(4'd8, 32'd3, 32'd4, res, lat);
        checkOutput("matr1_res", res, 32'd12);
        runMulOp(4'd8, 32'd2, 32'd5, res, lat);
        checkOutput("matr2_res", res, 32'd22);
        applyStimulus(1'b1, 4'd8, 32'd7, 32'd7, 1'b0);
        idleCycle();
        doReset();
        runMulOp(4'd8, 32'd1, 32'd1, res, lat);
        checkOutput("matr_after_rst", res, 32'd1);

        // mult 9*9 flushed at cycle 10, then an add
        applyStimulus(1'b1, 4'd1, 32'd9, 32'd9, 1'b0);
        for (int i = 0; i < 8; i++) idleCycle();
        applyStimulus(1'b0, 4'd0, '0, '0, 1'b1);
        checkOutput("flush_mul_stall", {31'd0, stall}, 32'd0);
        checkOutput("flush_mul_vld", {31'd0, out_valid}, 32'd0);
        applyStimulus(1'b1, 4'd2, 32'd20, 32'd22, 1'b0);
        checkOutput("post_flush_add", result, 32'd42);

        // randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            code = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 8);
            if ((code == 1 || code == 8) && $urandom_range(0, 5) != 0) begin
                // keep most multiplies from dominating the cycle budget
                code = $urandom_range(2, 7);
            end
            applyStimulus($urandom_range(0, 9) < 7, 4'(code), $urandom,
                          ($urandom_range(0, 1) == 1) ? $urandom : XLEN'($urandom_range(0, 40)),
                          $urandom_range(0, 19) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
